// File: rtl/main_memory_lat.sv
// Single-port backing memory with programmable read/write wait states.
// Optional stored-parity checking is enabled by defining MAIN_MEM_PARITY_EN.
module main_memory_lat #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 512,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [AWIDTH-1:0] addr_mem,
  input  logic [DWIDTH-1:0] data_in,
  output logic              ready_mem,
  output logic [DWIDTH-1:0] data_out,
  output logic              rd_valid,
  output logic              err_mem
`ifdef MAIN_MEM_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MAIN_MEM_PARITY_EN
  localparam int MW     = DWIDTH + 1;
`else
  localparam int MW     = DWIDTH;
`endif

  if (RD_LAT < 1 || RD_LAT > 15 || WR_LAT < 1 || WR_LAT > 15) begin : g_bad_lat
    $error("main_memory_lat: RD_LAT/WR_LAT must be 1..15");
  end
  if (DEPTH < 1 || DEPTH > (1 << AWIDTH)) begin : g_bad_depth
    $error("main_memory_lat: DEPTH must be 1..2**AWIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] data_q;
  logic              take;
  logic              do_rd;
  logic              do_wr;
  logic              req_err;
  logic              in_range;
  logic [IW-1:0]     idx;
  logic [MW-1:0]     rd_word;
  logic [MW-1:0]     wr_word;

  logic [MW-1:0]     mem [DEPTH];

  assign in_range = int'(addr_q) < DEPTH;
  assign idx      = addr_q[IW-1:0];
  assign rd_word  = mem[idx];
`ifdef MAIN_MEM_PARITY_EN
  assign wr_word  = {^data_q, data_q};
`else
  assign wr_word  = data_q;
`endif

  // next-state decode: accept in IDLE, count down wait states otherwise
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    take     = 1'b0;
    do_rd    = 1'b0;
    do_wr    = 1'b0;
    req_err  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_mem && wr_mem) begin
          req_err = 1'b1;
        end else if (rd_mem) begin
          take     = 1'b1;
          state_nx = RD_WAIT;
          cnt_nx   = CW'(RD_LAT - 1);
        end else if (wr_mem) begin
          take     = 1'b1;
          state_nx = WR_WAIT;
          cnt_nx   = CW'(WR_LAT - 1);
        end
      end
      RD_WAIT: begin
        if (cnt == '0) begin
          do_rd    = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      WR_WAIT: begin
        if (cnt == '0) begin
          do_wr    = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // control state, request latches and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      ready_mem <= 1'b1;
      data_out  <= '0;
      rd_valid  <= 1'b0;
      err_mem   <= 1'b0;
`ifdef MAIN_MEM_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ready_mem <= (state_nx == IDLE);
      rd_valid  <= do_rd;
      err_mem   <= req_err | ((do_rd | do_wr) & ~in_range);
      if (take) begin
        addr_q <= addr_mem;
        data_q <= data_in;
      end
      if (do_rd) begin
        data_out <= in_range ? rd_word[DWIDTH-1:0] : '0;
      end
`ifdef MAIN_MEM_PARITY_EN
      par_err <= do_rd & in_range &
                 (rd_word[DWIDTH] != ^rd_word[DWIDTH-1:0]);
`endif
    end
  end

  // array write at completion; never reset, dropped when out of range
  always_ff @(posedge clk) begin
    if (do_wr && in_range) begin
      mem[idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_main_memory_lat.sv
// Directed bench for main_memory_lat: default instance plus a
// DEPTH=300 / WR_LAT=3 instance for range and reset-abort cases.
module tb_main_memory_lat;

  logic       clk;
  logic       reset_n;
  logic       rd   [2];
  logic       wr   [2];
  logic [8:0] ad   [2];
  logic [7:0] di   [2];
  logic       rdy  [2];
  logic [7:0] dout [2];
  logic       rv   [2];
  logic       er   [2];
`ifdef MAIN_MEM_PARITY_EN
  logic       pe   [2];
  logic       want_pe;
`endif

  int total;
  int bad;
  int n;

  main_memory_lat dut0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_mem   (rd[0]),
    .wr_mem   (wr[0]),
    .addr_mem (ad[0]),
    .data_in  (di[0]),
    .ready_mem(rdy[0]),
    .data_out (dout[0]),
    .rd_valid (rv[0]),
    .err_mem  (er[0])
`ifdef MAIN_MEM_PARITY_EN
    ,
    .par_err  (pe[0])
`endif
  );

  main_memory_lat #(
    .DEPTH (300),
    .RD_LAT(2),
    .WR_LAT(3)
  ) dut1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_mem   (rd[1]),
    .wr_mem   (wr[1]),
    .addr_mem (ad[1]),
    .data_in  (di[1]),
    .ready_mem(rdy[1]),
    .data_out (dout[1]),
    .rd_valid (rv[1]),
    .err_mem  (er[1])
`ifdef MAIN_MEM_PARITY_EN
    ,
    .par_err  (pe[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_op(input int s, input logic [8:0] a,
                       input logic [7:0] d, input logic e);
    int k;
    @(negedge clk);
    wr[s] = 1'b1;
    ad[s] = a;
    di[s] = d;
    @(negedge clk);
    wr[s] = 1'b0;
    chk("wr_busy", 32'(rdy[s]), 32'd0);
    k = 0;
    while (!rdy[s] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("wr_lat", 32'(k), (s == 0) ? 32'd1 : 32'd3);
    chk("wr_err", 32'(er[s]), 32'(e));
  endtask

  task automatic rd_op(input int s, input logic [8:0] a,
                       input logic [7:0] d, input logic e);
    int k;
    @(negedge clk);
    rd[s] = 1'b1;
    ad[s] = a;
    @(negedge clk);
    rd[s] = 1'b0;
    chk("rd_busy", 32'(rdy[s]), 32'd0);
    k = 0;
    while (!rv[s] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rd_lat", 32'(k), 32'd2);
    chk("rd_ready", 32'(rdy[s]), 32'd1);
    chk("rd_data", 32'(dout[s]), 32'(d));
    chk("rd_err", 32'(er[s]), 32'(e));
`ifdef MAIN_MEM_PARITY_EN
    chk("rd_par", 32'(pe[s]), 32'(want_pe));
`endif
    @(negedge clk);
    chk("rv_pulse", 32'(rv[s]), 32'd0);
    chk("rd_hold", 32'(dout[s]), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
`ifdef MAIN_MEM_PARITY_EN
    want_pe = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0;
      wr[i] = 1'b0;
      ad[i] = '0;
      di[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_dout", 32'(dout[0]), 32'd0);
    chk("rst_rv", 32'(rv[0]), 32'd0);
    chk("rst_err", 32'(er[0]), 32'd0);
    chk("rst_ready1", 32'(rdy[1]), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(rdy[0]), 32'd1);

    wr_op(0, 9'h010, 8'hA5, 1'b0);
    rd_op(0, 9'h010, 8'hA5, 1'b0);

    @(negedge clk);
    rd[0] = 1'b1;
    wr[0] = 1'b1;
    @(negedge clk);
    chk("both_err", 32'(er[0]), 32'd1);
    chk("both_ready", 32'(rdy[0]), 32'd1);
    rd[0] = 1'b0;
    wr[0] = 1'b0;
    @(negedge clk);
    chk("both_err_end", 32'(er[0]), 32'd0);
    chk("both_hold", 32'(dout[0]), 32'hA5);

    rd[0] = 1'b1;
    ad[0] = 9'h010;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rd[0] = 1'b0;
      if (rv[0]) n++;
    end
    chk("busy_ignore", 32'(n), 32'd1);

    @(negedge clk);
    wr[0] = 1'b1;
    ad[0] = 9'h1FF;
    di[0] = 8'h3C;
    @(negedge clk);
    wr[0] = 1'b0;
    rd[0] = 1'b1;
    chk("b2b_wbusy", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    chk("b2b_ready", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    rd[0] = 1'b0;
    chk("b2b_accept", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    chk("b2b_wait", 32'(rv[0]), 32'd0);
    @(negedge clk);
    chk("b2b_rv", 32'(rv[0]), 32'd1);
    chk("b2b_data", 32'(dout[0]), 32'h3C);

    wr_op(0, 9'h000, 8'h11, 1'b0);
    rd_op(0, 9'h000, 8'h11, 1'b0);
    rd_op(0, 9'h1FF, 8'h3C, 1'b0);

    wr_op(1, 9'h020, 8'h55, 1'b0);
    @(negedge clk);
    wr[1] = 1'b1;
    ad[1] = 9'h020;
    di[1] = 8'hAA;
    @(negedge clk);
    wr[1] = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_ready", 32'(rdy[1]), 32'd1);
    chk("async_dout", 32'(dout[0]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_op(1, 9'h020, 8'h55, 1'b0);

    @(negedge clk);
    rd[1] = 1'b1;
    ad[1] = 9'h020;
    @(negedge clk);
    rd[1] = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rv[1]) n++;
    end
    chk("rst_rd_abort", 32'(n), 32'd0);
    chk("rst_rd_dout", 32'(dout[1]), 32'd0);

    rd_op(1, 9'h1F0, 8'h00, 1'b1);
    wr_op(1, 9'h1F0, 8'h77, 1'b1);
    wr_op(1, 9'd299, 8'h5A, 1'b0);
    rd_op(1, 9'd299, 8'h5A, 1'b0);
    rd_op(1, 9'd300, 8'h00, 1'b1);

`ifdef MAIN_MEM_PARITY_EN
    wr_op(0, 9'h030, 8'h0F, 1'b0);
    rd_op(0, 9'h030, 8'h0F, 1'b0);
    @(negedge clk);
    dut0.mem[9'h030][8] = ~dut0.mem[9'h030][8];
    want_pe = 1'b1;
    rd_op(0, 9'h030, 8'h0F, 1'b0);
    want_pe = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
